// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a length-prefixed, XOR-checksummed byte stream
// into big-endian 32-bit words, writes them to instruction memory and releases core reset.
module prog_loader #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic          restart,
    output logic          imwe,
    output logic [AW-1:0] imwa,
    output logic [31:0]   imwd,
    output logic          core_rst,
    output logic          done,
    output logic          error,
    output logic [AW:0]   word_cnt
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH    = 17'(2**AW);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t       state;
    state_t       state_next;
    logic [15:0]  len;
    logic [23:0]  shift;
    logic [1:0]   byte_cnt;
    logic [7:0]   xor_acc;
    logic         accept;
    logic [15:0]  len_rx;
    logic [15:0]  cnt_inc;
    logic         word_end;

    assign accept   = rx_valid & rx_ready;
    assign len_rx   = {len[15:8], rx_data};
    assign cnt_inc  = 16'(word_cnt) + 16'd1;
    assign word_end = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_HI: begin
                if (accept) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_rx} > DEPTH) begin
                        state_next = S_ERR;
                    end else if (len_rx == 16'd0) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_end && (cnt_inc == len)) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == xor_acc) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (restart) state_next = S_LEN_HI;
            end
            default: state_next = S_LEN_HI;
        endcase
    end

    // Status outputs and rx_ready are registered from the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready <= 1'b0;
            imwe     <= 1'b0;
            imwa     <= '0;
            imwd     <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            word_cnt <= '0;
            len      <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            xor_acc  <= '0;
        end else begin
            rx_ready <= (state_next == S_LEN_HI) || (state_next == S_LEN_LO) ||
                        (state_next == S_DATA)   || (state_next == S_CSUM);
            done     <= (state_next == S_DONE);
            error    <= (state_next == S_ERR);
            core_rst <= (state_next != S_DONE);
            imwe     <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (accept) len[15:8] <= rx_data;
                end
                S_LEN_LO: begin
                    if (accept) len[7:0] <= rx_data;
                end
                S_DATA: begin
                    if (accept) begin
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], rx_data};
                    end
                    if (word_end) begin
                        imwe     <= 1'b1;
                        imwa     <= word_cnt[AW-1:0];
                        imwd     <= {shift, rx_data};
                        word_cnt <= word_cnt + CNT_ONE;
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        word_cnt <= '0;
                        xor_acc  <= '0;
                        byte_cnt <= '0;
                        len      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver queues expected memory writes as it
// sends bytes, a negedge monitor pops and checks each IMWE pulse (address, data, latency).
module tb_prog_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          restart = 1'b0;
    logic          rx_ready;
    logic          imwe;
    logic [AW-1:0] imwa;
    logic [31:0]   imwd;
    logic          core_rst;
    logic          done;
    logic          error;
    logic [AW:0]   word_cnt;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stream[$];
    logic [31:0] words[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;

    prog_loader #(.AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .restart  (restart),
        .imwe     (imwe),
        .imwa     (imwa),
        .imwd     (imwd),
        .core_rst (core_rst),
        .done     (done),
        .error    (error),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Each write must match the head of the queue and appear one cycle after its 4th byte.
    always @(negedge clk) begin
        if (rst_n && imwe) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got write at addr 0x%0h data 0x%0h, expected none",
                         imwa, imwd);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("imwa", 32'(imwa), 32'(mon_e.addr));
                checkOutput("imwd", imwd, mon_e.data);
                checkOutput("imwe_latency", cyc, mon_e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic sendByte(input logic [7:0] b, input bit push, input int idx);
        int  waitc;
        wr_t w;
        waitc    = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL handshake_timeout: got rx_ready=0 for 20 cycles, expected 1");
            rx_valid = 1'b0;
            return;
        end
        if (push) begin
            w.addr = AW'(idx);
            w.data = words[idx];
            w.cyc  = cyc + 1;
            exp_q.push_back(w);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int max_gap);
        int k;
        k = 0;
        for (int i = 0; i < stream.size(); i++) begin
            bit wend;
            wend = (i >= 2) && (i < stream.size() - 1) && (((i - 2) % 4) == 3);
            sendByte(stream[i], wend, k);
            if (wend) k++;
            if (max_gap > 0 && i != stream.size() - 1)
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic doRestart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checkOutput("restart_core_rst", 32'(core_rst), 32'd1);
        checkOutput("restart_done", 32'(done), 32'd0);
        checkOutput("restart_error", 32'(error), 32'd0);
        checkOutput("restart_word_cnt", 32'(word_cnt), 32'd0);
        checkOutput("restart_rx_ready", 32'(rx_ready), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        checkOutput({tag, "_imwe"}, 32'(imwe), 32'd0);
        checkOutput({tag, "_imwa"}, 32'(imwa), 32'd0);
        checkOutput({tag, "_imwd"}, imwd, 32'd0);
        checkOutput({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic checkDrained(input string tag);
        checkOutput({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by 200000, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("first_cycle_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        checkOutput("post_reset_rx_ready", 32'(rx_ready), 32'd1);

        // Two-word image; checksum = 20^08^00^05^20^09^00^0A = 0x0E.
        words  = '{32'h2008_0005, 32'h2009_000A};
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        applyStimulus(0);
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_core_rst", 32'(core_rst), 32'd0);
        checkOutput("t1_error", 32'(error), 32'd0);
        checkOutput("t1_word_cnt", 32'(word_cnt), 32'd2);
        checkOutput("t1_rx_ready", 32'(rx_ready), 32'd0);
        checkDrained("t1");

        doRestart();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h01};
        applyStimulus(0);
        checkOutput("t2_error", 32'(error), 32'd1);
        checkOutput("t2_done", 32'(done), 32'd0);
        checkOutput("t2_core_rst", 32'(core_rst), 32'd1);
        checkOutput("t2_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("t2_word_cnt", 32'(word_cnt), 32'd2);
        checkDrained("t2");

        doRestart();
        stream = '{8'h00, 8'h00, 8'h00};
        applyStimulus(0);
        checkOutput("t3_done", 32'(done), 32'd1);
        checkOutput("t3_core_rst", 32'(core_rst), 32'd0);
        checkOutput("t3_word_cnt", 32'(word_cnt), 32'd0);

        doRestart();
        stream = '{8'h00, 8'h00, 8'h05};
        applyStimulus(0);
        checkOutput("t4_error", 32'(error), 32'd1);
        checkOutput("t4_done", 32'(done), 32'd0);

        doRestart();
        stream = '{8'h01, 8'h01};
        applyStimulus(0);
        checkOutput("t5_error", 32'(error), 32'd1);
        checkOutput("t5_rx_ready", 32'(rx_ready), 32'd0);
        checkOutput("t5_core_rst", 32'(core_rst), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("t5_word_cnt", 32'(word_cnt), 32'd0);

        doRestart();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        applyStimulus(5);
        checkOutput("t6_done", 32'(done), 32'd1);
        checkOutput("t6_word_cnt", 32'(word_cnt), 32'd2);
        checkDrained("t6");

        doRestart();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
        applyStimulus(0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midload");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        applyStimulus(0);
        checkOutput("t7_done", 32'(done), 32'd1);
        checkOutput("t7_core_rst", 32'(core_rst), 32'd0);
        checkDrained("t7");

        // N equal to the memory depth is legal and must not abort.
        doRestart();
        stream = '{8'h01, 8'h00};
        applyStimulus(0);
        checkOutput("depth_error", 32'(error), 32'd0);
        checkOutput("depth_rx_ready", 32'(rx_ready), 32'd1);

        repeat (3) @(negedge clk);
        checkDrained("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
